booth_mac_accum: RTL and testbench
==================================

# booth_mac_accum

Multiply-accumulate back end for the 16x16 signed Booth multiplier. It issues operand pairs to the multiplier under a valid/ready handshake, tracks each product through the multiplier's registered latency, and sums the products into a saturating 40-bit signed accumulator. At the end of each burst it presents the total on a held valid/ready output port. It sits directly downstream of `mul16x16_signed`, whose `P` output feeds this block's `P` input.

## Interface

**Parameters**
- `ACC_W`, default 40: accumulator width; must be at least 32.
- `CNT_W`, default 8: width of the product counter.
- `MUL_LAT`, default 1: cycles from `A`/`B` being sampled at the multiplier to `P` being valid.

**Ports**
- `CLK` input 1: the single clock; every register updates on its rising edge.
- `RST` input 1: synchronous, active-high reset.
- `in_valid` input 1: the upstream `A`/`B` pair at the multiplier inputs is valid this cycle.
- `in_last` input 1: qualifies the final pair of a burst; sampled only on acceptance.
- `in_ready` output 1: this block accepts a pair this cycle.
- `acc_clr` input 1: discard the running sum; honoured in state ACCUM only.
- `P` input 32, signed: product from `mul16x16_signed`.
- `out_valid` output 1: `out_acc`, `out_count` and `out_ovf` hold a completed burst.
- `out_ready` input 1: the downstream consumer takes the result.
- `out_acc` output ACC_W, signed: the accumulated sum.
- `out_count` output CNT_W: the number of products summed.
- `out_ovf` output 1: sticky flag, set when any saturation occurred in the burst.

## Operation

- **Acceptance:** a pair is accepted when `in_valid && in_ready`. `in_ready` is high only in ACCUM.
- **Product tracking:** a valid shift register of depth MUL_LAT carries {valid, last} for each accepted pair. The stage-MUL_LAT tap marks the cycle in which `P` belongs to that pair.
- **Accumulate step:** on a tap-valid cycle:
  - `acc <= sat(acc + sign_extend(P))`.
  - `count <= count + 1`, saturating at 2^CNT_W-1.
  - If saturation occurs, `ovf <= 1`.
- **Saturation rule:** if both addends share a sign and the raw sum's sign differs, the result clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1).
- **State machine** (states ACCUM, DRAIN, HOLD):
  - ACCUM: accepting a pair with `in_last` moves to DRAIN.
  - DRAIN: `in_ready` is 0. When the tap shows valid&&last, perform that final add and move to HOLD.
  - HOLD: `out_valid` = 1 and the outputs are frozen. On `out_ready`, move to ACCUM and clear acc, count and ovf.
- **Clear:**
  - In ACCUM, `acc_clr` zeroes acc, count and ovf at the next edge.
  - If a tap-valid product arrives in the same cycle, the result is acc = sign_extend(P), count = 1 and ovf = 0.
  - `acc_clr` is ignored in DRAIN and HOLD.
- **Single-product burst:** a burst with `in_last` on its first pair is legal and yields count = 1.
- **Reset:**
  - `RST` forces state ACCUM and clears the shift register, acc, count and ovf.
  - Products already in flight inside the multiplier are dropped.
  - Reset values: `in_ready` = 1, `out_valid` = 0, `out_acc` = 0, `out_count` = 0, `out_ovf` = 0.
- **Unqualified inputs:** `in_last` without `in_valid`, and `out_ready` outside HOLD, have no effect.

## Timing

- **Output latency:** for a pair accepted in cycle t, its product is added at the edge that ends cycle t+MUL_LAT. For the last pair, `out_valid` rises in cycle t+MUL_LAT+1.
- **Throughput:** one pair per cycle in ACCUM.
- **Burst turnaround:** the minimum gap between bursts is MUL_LAT+1 cycles of DRAIN/HOLD, plus the wait for `out_ready`.
- **Output handshake:** `out_valid` stays high, and the outputs stay stable, until the cycle in which `out_ready` is sampled high. `in_ready` returns high in the following cycle.
- **Combinational paths:**
  - `in_ready` and `out_valid` depend on state only.
  - There is no combinational path from `P` to any output.

## Structure

- **Shared package `booth_mac_pkg`:**
  - State enum {ACCUM, DRAIN, HOLD}.
  - Defaults for ACC_W and CNT_W.
  - Saturation limit constants derived from ACC_W.
- **Sub-module `booth_sat_add`:** combinational. Inputs are the ACC_W accumulator and the 32-bit signed product; outputs are the saturated sum and a saturate flag.
- **Placement:** the multiplier stays external and is wired at the top level.

## Test plan

- **Basic burst:** pairs (3,4), (-5,6), (7,-8) with last on the third (P = 12, -30, -56) -> `out_valid` in cycle t3+2, `out_acc` = -74, `out_count` = 3, `out_ovf` = 0.
- **Output backpressure:** hold `out_ready` = 0 for 5 cycles -> outputs stable and `in_ready` = 0 throughout. Pulse `out_ready` -> `in_ready` = 1 next cycle, and the next burst (2,2 last) gives 4.
- **Positive saturation, ACC_W = 33:** repeat (-32768,-32768), P = 2^30, 5 times -> `out_acc` = 2^32-1, `out_ovf` = 1, `out_count` = 5.
- **Clear collision:** assert `acc_clr` in the cycle the product of (10,10) is at the tap, with acc = 500 -> acc = 100, count = 1.
- **Mid-burst reset:** assert `RST` one cycle after accepting (9,9) last -> no `out_valid`, all outputs 0. A new burst (1,1 last) gives 1.
- **Single pair with clear in DRAIN:** (-32768,32767) last -> -1073709056, count = 1. An `acc_clr` asserted during DRAIN is ignored.

Source files
------------

// File: rtl/booth_mac_accum_pkg.sv
// Shared state encoding, pipeline tag type and saturation limits for the
// Booth multiply-accumulate back end.
package booth_mac_pkg;

    localparam int ACC_W_DEF = 40;
    localparam int CNT_W_DEF = 8;
    localparam int PROD_W    = 32;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } mac_state_t;

    // One entry per accepted pair while its product is inside the multiplier.
    typedef struct packed {
        logic valid;
        logic last;
    } tap_t;

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/booth_mac_accum_if.sv
// Operand handshake, product input and result handshake between the
// Booth multiplier front end, this accumulator and its consumer.
interface booth_mac_if #(
    parameter int ACC_W = booth_mac_pkg::ACC_W_DEF,
    parameter int CNT_W = booth_mac_pkg::CNT_W_DEF
) ();

    logic                    in_valid;
    logic                    in_last;
    logic                    in_ready;
    logic                    acc_clr;
    logic signed [31:0]      P;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0]        out_count;
    logic                    out_ovf;

    modport master (
        output in_valid, in_last, acc_clr, P, out_ready,
        input  in_ready, out_valid, out_acc, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_last, acc_clr, P, out_ready,
        output in_ready, out_valid, out_acc, out_count, out_ovf
    );

endinterface

// File: rtl/booth_sat_add.sv
// Signed saturating add of a 32-bit product into an ACC_W-bit accumulator.
module booth_sat_add
    import booth_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic signed [PROD_W-1:0] prod,
    output logic signed [ACC_W-1:0]  sum,
    output logic                     sat
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] raw;

    // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        prod_ext = ACC_W'(prod);
        raw      = acc + prod_ext;
        sat      = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
        sum      = raw;
        if (sat) begin
            sum = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
    end

endmodule

// File: rtl/booth_mac_accum.sv
// Accumulates products of the external 16x16 signed multiplier into a
// saturating sum and presents each burst total on a held valid/ready port.
module booth_mac_accum
    import booth_mac_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int MUL_LAT = 1
) (
    input  logic       CLK,
    input  logic       RST,
    booth_mac_if.slave bus
);

    mac_state_t              state;
    tap_t                    pipe [MUL_LAT];
    tap_t                    tap;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        count_base;
    logic                    ovf;
    logic                    sat;
    logic                    accept;
    logic                    clr;

    assign accept = bus.in_valid && (state == ACCUM);
    assign clr    = bus.acc_clr && (state == ACCUM);
    assign tap    = pipe[MUL_LAT-1];

    // A clear landing with a product folds into the add: the product starts a fresh sum.
    assign acc_base   = clr ? '0 : acc;
    assign count_base = clr ? '0 : count;

    booth_sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .acc  (acc_base),
        .prod (bus.P),
        .sum  (acc_next),
        .sat  (sat)
    );

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ACCUM;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            // NOTE: the tag pipe is reset so products still inside the multiplier are never added.
            for (int i = 0; i < MUL_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= {accept, accept && bus.in_last};
            for (int i = 1; i < MUL_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end

            if (tap.valid) begin
                acc   <= acc_next;
                count <= (count_base == '1) ? count_base : count_base + 1'b1;
                ovf   <= (ovf && !clr) || sat;
            end else if (clr) begin
                acc   <= '0;
                count <= '0;
                ovf   <= 1'b0;
            end

            case (state)
                ACCUM: if (accept && bus.in_last) state <= DRAIN;
                DRAIN: if (tap.valid && tap.last) state <= HOLD;
                HOLD: begin
                    if (bus.out_ready) begin
                        state <= ACCUM;
                        acc   <= '0;
                        count <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_acc   = acc;
    assign bus.out_count = count;
    assign bus.out_ovf   = ovf;

endmodule

// File: tb/tb_booth_mac_accum.sv
// Self-checking bench: one 40-bit and one 33-bit accumulator share stimulus and a
// registered multiplier model; burst totals are checked against a clamp-based sum model.
module tb_booth_mac_accum;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic               in_valid;
    logic               in_last;
    logic               acc_clr;
    logic               out_ready;
    logic signed [15:0] A;
    logic signed [15:0] B;
    logic signed [31:0] P;

    int checks = 0;
    int errors = 0;

    longint prods[$];
    longint exp_acc40;
    longint exp_acc33;
    longint exp_cnt;
    bit     exp_ovf40;
    bit     exp_ovf33;

    booth_mac_if #(.ACC_W(40), .CNT_W(8)) b40 ();
    booth_mac_if #(.ACC_W(33), .CNT_W(8)) b33 ();

    // Stand-in for mul16x16_signed: one registered stage from A/B to P.
    always @(posedge CLK) P <= 32'(A) * 32'(B);

    assign b40.in_valid  = in_valid;
    assign b40.in_last   = in_last;
    assign b40.acc_clr   = acc_clr;
    assign b40.out_ready = out_ready;
    assign b40.P         = P;
    assign b33.in_valid  = in_valid;
    assign b33.in_last   = in_last;
    assign b33.acc_clr   = acc_clr;
    assign b33.out_ready = out_ready;
    assign b33.P         = P;

    booth_mac_accum #(.ACC_W(40), .CNT_W(8), .MUL_LAT(1)) dut40 (
        .CLK (CLK),
        .RST (RST),
        .bus (b40.slave)
    );

    booth_mac_accum #(.ACC_W(33), .CNT_W(8), .MUL_LAT(1)) dut33 (
        .CLK (CLK),
        .RST (RST),
        .bus (b33.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sum of a burst's products with clamping to the signed w-bit range after each add.
    function automatic void burst_model(input int w, input longint q[$],
                                        output longint acc, output longint cnt, output bit ovf);
        longint hi;
        longint lo;
        hi  = (longint'(1) <<< (w - 1)) - 1;
        lo  = -hi - 1;
        acc = 0;
        cnt = 0;
        ovf = 1'b0;
        foreach (q[i]) begin
            acc += q[i];
            if (acc > hi) begin
                acc = hi;
                ovf = 1'b1;
            end else if (acc < lo) begin
                acc = lo;
                ovf = 1'b1;
            end
            if (cnt < 255) cnt++;
        end
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input int a, input int b, input bit last);
        check("push.in_ready40", b40.in_ready, 1);
        check("push.in_ready33", b33.in_ready, 1);
        in_valid = 1'b1;
        in_last  = last;
        A        = 16'(a);
        B        = 16'(b);
        prods.push_back(longint'(a) * longint'(b));
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called in the cycle after the last pair was accepted.
    task automatic finish_burst(input string tag, input bit clr_in_drain);
        longint c33;
        check({tag, ".drain_out_valid"}, b40.out_valid, 0);
        check({tag, ".drain_in_ready"}, b40.in_ready, 0);
        acc_clr = clr_in_drain;
        tick();
        acc_clr = 1'b0;
        burst_model(40, prods, exp_acc40, exp_cnt, exp_ovf40);
        burst_model(33, prods, exp_acc33, c33, exp_ovf33);
        prods.delete();
        check({tag, ".out_valid40"}, b40.out_valid, 1);
        check({tag, ".out_valid33"}, b33.out_valid, 1);
        check({tag, ".acc40"}, {24'b0, b40.out_acc}, {24'b0, 40'(exp_acc40)});
        check({tag, ".count40"}, b40.out_count, exp_cnt[7:0]);
        check({tag, ".ovf40"}, b40.out_ovf, exp_ovf40);
        check({tag, ".acc33"}, {31'b0, b33.out_acc}, {31'b0, 33'(exp_acc33)});
        check({tag, ".count33"}, b33.out_count, c33[7:0]);
        check({tag, ".ovf33"}, b33.out_ovf, exp_ovf33);
    endtask

    task automatic collect(input string tag, input int wait_cycles, input bit clr_in_hold);
        for (int i = 0; i < wait_cycles; i++) begin
            acc_clr = clr_in_hold && (i % 2 == 0);
            tick();
            check({tag, ".hold_valid"}, b40.out_valid, 1);
            check({tag, ".hold_in_ready"}, b40.in_ready, 0);
            check({tag, ".hold_acc40"}, {24'b0, b40.out_acc}, {24'b0, 40'(exp_acc40)});
            check({tag, ".hold_acc33"}, {31'b0, b33.out_acc}, {31'b0, 33'(exp_acc33)});
            check({tag, ".hold_count"}, b40.out_count, exp_cnt[7:0]);
        end
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".after_out_valid"}, b40.out_valid, 0);
        check({tag, ".after_in_ready40"}, b40.in_ready, 1);
        check({tag, ".after_in_ready33"}, b33.in_ready, 1);
        check({tag, ".after_count"}, b40.out_count, 0);
        check({tag, ".after_ovf33"}, b33.out_ovf, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int len;
        int a;
        int b;

        RST       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        repeat (3) tick();
        RST = 1'b0;

        check("reset.in_ready", b40.in_ready, 1);
        check("reset.out_valid", b40.out_valid, 0);
        check("reset.out_acc", {24'b0, b40.out_acc}, 0);
        check("reset.out_count", b40.out_count, 0);
        check("reset.out_ovf", b40.out_ovf, 0);
        tick();

        // Basic burst: 12 - 30 - 56 = -74.
        push(3, 4, 0);
        push(-5, 6, 0);
        push(7, -8, 1);
        finish_burst("basic", 0);
        check("basic.acc_const", {24'b0, b40.out_acc}, {24'b0, 40'(-74)});

        // Five cycles of backpressure, with clears in HOLD that must be ignored.
        collect("backpressure", 5, 1);
        push(2, 2, 1);
        finish_burst("after_bp", 0);
        collect("after_bp", 0, 0);

        // 5 x 2^30: saturates the 33-bit instance at 2^32-1, not the 40-bit one.
        for (int i = 0; i < 5; i++) push(-32768, -32768, i == 4);
        finish_burst("pos_sat", 0);
        check("pos_sat.acc33_const", {31'b0, b33.out_acc}, {31'b0, 33'h0_FFFF_FFFF});
        check("pos_sat.ovf33_const", b33.out_ovf, 1);
        collect("pos_sat", 1, 0);

        // Clear in the same cycle the (10,10) product is at the tap, sum = 500 beforehand.
        push(20, 25, 0);
        push(10, 10, 0);
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        prods.delete(0);
        push(0, 5, 1);
        finish_burst("clr_collide", 0);
        collect("clr_collide", 0, 0);

        // Reset one cycle after the last pair is accepted drops its product.
        push(9, 9, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        prods.delete();
        for (int i = 0; i < 3; i++) begin
            check("mid_rst.out_valid", b40.out_valid, 0);
            check("mid_rst.in_ready", b40.in_ready, 1);
            check("mid_rst.out_acc", {24'b0, b40.out_acc}, 0);
            check("mid_rst.out_count", b40.out_count, 0);
            check("mid_rst.out_ovf", b40.out_ovf, 0);
            tick();
        end
        push(1, 1, 1);
        finish_burst("post_rst", 0);
        collect("post_rst", 0, 0);

        // Single-pair burst with a clear during DRAIN, then a two-pair one.
        push(-32768, 32767, 1);
        finish_burst("single_clr", 1);
        check("single_clr.acc_const", {24'b0, b40.out_acc}, {24'b0, 40'(-1073709056)});
        collect("single_clr", 0, 0);
        push(7, 7, 0);
        push(-32768, 32767, 1);
        finish_burst("drain_clr", 1);
        collect("drain_clr", 1, 0);

        // Random bursts; idle gaps carry unqualified in_last and out_ready.
        for (int n = 0; n < 8; n++) begin
            len = int'($urandom_range(1, 7));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_last   = 1'b1;
                    out_ready = 1'b1;
                    tick();
                    in_last   = 1'b0;
                    out_ready = 1'b0;
                end
                a = int'($urandom_range(0, 65535)) - 32768;
                b = int'($urandom_range(0, 65535)) - 32768;
                push(a, b, k == len - 1);
            end
            finish_burst("random", 0);
            collect("random", int'($urandom_range(0, 3)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
